// File: rtl/button_conditioner.sv
// Conditions raw push-buttons into debounced levels and one-hot, single-cycle load strobes.
// Each accepted press is queued in a pending bit and granted lowest index first, one per cycle.
module button_conditioner #(
    parameter int NB_BUTTONS      = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_COUNT        = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_BUTTONS-1:0] i_buttons,
    output logic [NB_BUTTONS-1:0] o_pulse,
    output logic [NB_BUTTONS-1:0] o_level
);

    // The toggle happens on the edge where the counter would reach DEBOUNCE_CYCLES.
    localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);

    logic [NB_BUTTONS-1:0]               sync1, sync2;
    logic [NB_BUTTONS-1:0][NB_COUNT-1:0] cnt, cnt_next;
    logic [NB_BUTTONS-1:0]               level_next;
    logic [NB_BUTTONS-1:0]               pending, pending_next;
    logic [NB_BUTTONS-1:0]               rise, grant;

    always_comb begin
        cnt_next   = cnt;
        level_next = o_level;
        for (int k = 0; k < NB_BUTTONS; k++) begin
            if (sync2[k] == o_level[k]) begin
                cnt_next[k] = '0;
            end else if (cnt[k] == LAST) begin
                cnt_next[k]   = '0;
                level_next[k] = ~o_level[k];
            end else begin
                cnt_next[k] = cnt[k] + 1'b1;
            end
        end
    end

    // Only presses are queued; a same-edge acceptance overrides the grant clear.
    always_comb begin
        rise         = level_next & ~o_level;
        grant        = pending & (~pending + 1'b1);
        pending_next = (pending & ~grant) | rise;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            cnt     <= '0;
            o_level <= '0;
            pending <= '0;
            o_pulse <= '0;
        end else begin
            sync1   <= i_buttons;
            sync2   <= sync1;
            cnt     <= cnt_next;
            o_level <= level_next;
            pending <= pending_next;
            o_pulse <= grant;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner: a history-window reference model feeds a scoreboard
// that a negedge monitor drains, alongside per-cycle strobe invariants.
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int D  = 4;

    logic          i_clock   = 1'b0;
    logic          i_reset   = 1'b1;
    logic [NB-1:0] i_buttons = '0;
    logic [NB-1:0] o_pulse;
    logic [NB-1:0] o_level;

    button_conditioner #(.NB_BUTTONS(NB), .DEBOUNCE_CYCLES(D)) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_buttons(i_buttons),
        .o_pulse  (o_pulse),
        .o_level  (o_level)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic          rst;
        logic [NB-1:0] pulse;
        logic [NB-1:0] level;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: a level flips once the last D synchronized samples all disagree with it.
    logic [NB-1:0] raw[$];
    logic [NB-1:0] used[$];
    logic [NB-1:0] m_level = '0, m_pend = '0, m_pulse = '0;

    always @(posedge i_clock) begin
        exp_t          e;
        logic [NB-1:0] u, nl, gnt;
        if (i_reset) begin
            raw.delete();
            used.delete();
            m_level = '0;
            m_pend  = '0;
            m_pulse = '0;
        end else begin
            u = (raw.size() >= 2) ? raw[raw.size()-2] : '0;
            raw.push_back(i_buttons);
            used.push_back(u);
            nl = m_level;
            for (int k = 0; k < NB; k++) begin
                bit all;
                all = 1'b1;
                for (int j = 0; j < D; j++) begin
                    int  idx;
                    logic v;
                    idx = used.size() - 1 - j;
                    v   = (idx >= 0) ? used[idx][k] : 1'b0;
                    if (v == m_level[k]) all = 1'b0;
                end
                if (all) nl[k] = ~m_level[k];
            end
            gnt = '0;
            for (int k = 0; k < NB; k++)
                if (m_pend[k] && gnt == '0) gnt[k] = 1'b1;
            m_pend  = (m_pend & ~gnt) | (nl & ~m_level);
            m_pulse = gnt;
            m_level = nl;
        end
        e.rst   = i_reset;
        e.pulse = m_pulse;
        e.level = m_level;
        sb.push_back(e);
    end

    task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, want);
        end
    endtask

    // Monitor: scoreboard compare plus invariants on every cycle.
    exp_t          m_e;
    logic [NB-1:0] prev_pulse = '0, prev_level = '0;
    int            owed[NB];

    always @(negedge i_clock) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            chk("pulse", o_pulse, m_e.pulse);
            chk("level", o_level, m_e.level);
            checks++;
            if (!$onehot0(o_pulse)) begin
                fails++;
                $display("FAIL onehot0 @%0t: got %b expected at most one bit", $time, o_pulse);
            end
            checks++;
            if ((prev_pulse & o_pulse) != '0) begin
                fails++;
                $display("FAIL consecutive @%0t: got %b after %b expected no repeat", $time, o_pulse, prev_pulse);
            end
            if (m_e.rst) begin
                for (int k = 0; k < NB; k++) owed[k] = 0;
            end else begin
                for (int k = 0; k < NB; k++) begin
                    if (o_level[k] && !prev_level[k]) owed[k]++;
                    if (o_pulse[k]) begin
                        checks++;
                        if (owed[k] == 0) begin
                            fails++;
                            $display("FAIL pulse_without_rise @%0t: bit %0d got pulse expected none", $time, k);
                        end else begin
                            owed[k]--;
                        end
                    end
                end
            end
            prev_pulse = o_pulse;
            prev_level = o_level;
        end
    end

    task automatic hold(input logic [NB-1:0] b, input int n);
        i_buttons = b;
        repeat (n) begin
            @(posedge i_clock);
            #2;
        end
    endtask

    initial begin
        for (int k = 0; k < NB; k++) owed[k] = 0;
        i_reset = 1'b1;
        hold('0, 3);
        i_reset = 1'b0;
        hold(3'b000, 10);
        // clean press and release
        hold(3'b001, 20);
        hold(3'b000, 15);
        // glitch shorter than the debounce window
        hold(3'b010, 3);
        hold(3'b000, 15);
        // bounce then stable
        hold(3'b100, 1); hold(3'b000, 1); hold(3'b100, 2); hold(3'b000, 1);
        hold(3'b100, 20);
        hold(3'b000, 15);
        // simultaneous acceptance
        hold(3'b101, 20);
        hold(3'b000, 15);
        // all three at once
        hold(3'b111, 20);
        hold(3'b000, 15);
        // reset mid-press with button held through release
        hold(3'b001, 5);
        i_reset = 1'b1;
        hold(3'b001, 1);
        i_reset = 1'b0;
        hold(3'b001, 20);
        hold(3'b000, 15);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                i_reset = 1'b1;
                hold(NB'($urandom_range(0, (1 << NB) - 1)), 1);
                i_reset = 1'b0;
            end else begin
                hold(NB'($urandom_range(0, (1 << NB) - 1)), $urandom_range(1, 8));
            end
        end
        hold(3'b000, 20);
        @(negedge i_clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of the ALU operand-load top level.
- Takes the raw, asynchronous, bouncing push-button lines and emits clean one-hot, single-cycle load strobes: bit 0 loads A, bit 1 loads B, bit 2 loads the opcode.
- Gives one strobe per physical press, never two strobes in the same cycle, and a debounced level per button.

Parameters:
- NB_BUTTONS, 3, number of button lines conditioned.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks required to accept a level change. Legal range is 1 and above. Default is 10 ms at 100 MHz. Benches override it to 4.
- NB_COUNT, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter (derived).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_buttons  in  NB_BUTTONS  raw asynchronous button inputs, active-high.
- o_pulse  out  NB_BUTTONS  one-hot load strobe, at most one bit high, each high for exactly one cycle.
- o_level  out  NB_BUTTONS  debounced button state.

Behaviour:
- Reset: synchronous, active-high, on i_clock. Clears all of the following to 0 at the reset edge:
  - synchronizer flops
  - counters
  - o_level
  - pending register
  - o_pulse
- Reset has priority over all other updates in the same edge.
- Synchronizer: each bit passes through a 2-flop synchronizer (sync1, then sync2). Only sync2 feeds the logic below.
- Debounce, per bit k (independent counter cnt[k]):
  - If sync2[k] equals o_level[k], cnt[k] is cleared to 0.
  - Otherwise cnt[k] increments.
  - At the edge where cnt[k] would reach DEBOUNCE_CYCLES: o_level[k] toggles and cnt[k] clears.
  - Any return to the old level before then clears cnt[k]. Bounces restart the count.
- Timing: let N be the first edge that samples i_buttons[k] high, with the input stable afterwards.
  - sync2[k] goes high at edge N+1.
  - cnt[k] reaches 1 at edge N+2.
  - o_level[k] goes high at edge N+DEBOUNCE_CYCLES+1.
  - Release is symmetric: o_level[k] falls DEBOUNCE_CYCLES+1 edges after the first sampled low.
- Press acceptance: a 0->1 transition of o_level[k] sets pending[k] at the same edge. A 1->0 transition sets nothing.
- Arbiter:
  - Each edge, o_pulse is loaded with a one-hot vector selecting the lowest-index set bit of pending. That bit is cleared in pending.
  - If pending is empty, o_pulse is loaded with 0.
  - Uncontended press: o_pulse[k] is high for the single cycle after edge N+DEBOUNCE_CYCLES+2.
  - Simultaneous acceptances are served lowest index first, one per cycle. No press is lost.
- Same-edge events:
  - A bit being granted while its own new acceptance arrives on that edge: the set wins, so pending stays 1 and the second press is pulsed later.
  - A new acceptance for a bit already pending merges with it, giving one pulse. This is unreachable in practice because a debounce needs at least 2 edges.
- Reset mid-operation:
  - Any partial debounce and any pending strobes are discarded.
  - A button held through reset release is treated as a new press: o_pulse fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge that samples it high.
- DEBOUNCE_CYCLES=1: a change is accepted after one stable sync2 sample. Pulse timing follows the same formula.
- Invariants, which the bench must assert every cycle:
  - $onehot0(o_pulse).
  - o_pulse[k] is never high on two consecutive cycles.
  - o_pulse[k] is high only after a rising o_level[k].

Test Plan (NB_BUTTONS=3, DEBOUNCE_CYCLES=4):
- Clean press: i_buttons=001 first sampled at edge 10, held 20 cycles -> o_level[0]=1 from edge 15; o_pulse=001 for only the cycle after edge 16; o_pulse=000 otherwise.
- Glitch: i_buttons[1] high for 3 sampled cycles, then low -> o_level and o_pulse stay 000 throughout.
- Bounce: i_buttons[2] sampled 1,0,1,1,0, then 1 stable from edge M -> exactly one o_pulse=100, after edge M+6; o_level[2] rises at edge M+5.
- Simultaneous: buttons 0 and 2 both first sampled high at edge N -> o_pulse=001 after edge N+6, 100 after edge N+7, 000 after edge N+8.
- Release: button 0 held stable, then first sampled low at edge R -> o_level[0] falls at edge R+5; no o_pulse activity.
- Reset: i_reset high for 1 cycle at edge N+5 during a 001 press, then the button stays held -> all outputs 0 after edge N+5; o_level[0] rises at edge N+11; o_pulse=001 after edge N+12.
